ttl_serial_adder: RTL and testbench

TTL_SERIAL_ADDER -- requirements
Module: ttl_serial_adder

---
 rtl/ttl_adder_pkg.sv | 17 +
 rtl/adder_slice4.sv | 12 +
 rtl/ttl_serial_adder.sv | 116 +++++++++++
 tb/tb_ttl_serial_adder.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ttl_adder_pkg.sv
// rtl/ttl_adder_pkg.sv - mode and FSM state encodings shared by the serial adder and its bench
package ttl_adder_pkg;

  typedef enum logic [1:0] {
    MODE_ADD = 2'b00,
    MODE_SUB = 2'b01,
    MODE_ACC = 2'b10,
    MODE_CLR = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/adder_slice4.sv
// rtl/adder_slice4.sv - combinational 4-bit sum/carry slice (74283 equivalent)
module adder_slice4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  assign {co, s} = {1'b0, a} + {1'b0, b} + {4'b0000, ci};

endmodule

// File: rtl/ttl_serial_adder.sv
// rtl/ttl_serial_adder.sv - nibble-serial add/sub/accumulate unit, one 4-bit slice per cycle
module ttl_serial_adder
  import ttl_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int N     = WIDTH / SLICE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  if ((SLICE != 4) || ((WIDTH % 4) != 0) || (WIDTH < 4) || (WIDTH > 64)) begin : g_bad_param
    $error("ttl_serial_adder: WIDTH must be a multiple of 4 in 4..64 and SLICE must be 4");
  end

  state_e           state, state_nxt;
  logic             accept;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_r, b_r;
  logic             carry;
  logic             last;
  logic [3:0]       sl_a, sl_b, sl_s;
  logic             sl_co;

  assign last = (cnt == CNT_W'(N - 1));
  assign sl_a = a_r[{cnt, 2'b00} +: 4];
  assign sl_b = b_r[{cnt, 2'b00} +: 4];

  adder_slice4 u_slice (
    .a  (sl_a),
    .b  (sl_b),
    .ci (carry),
    .s  (sl_s),
    .co (sl_co)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = (mode_e'(mode) == MODE_CLR) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (last) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = (mode_e'(mode) == MODE_CLR) ? ST_DONE : ST_RUN;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operands are latched on accept, so ACC snapshots the result before nibbles are overwritten.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      a_r   <= '0;
      b_r   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      c_out <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      cnt <= '0;
      if (mode_e'(mode) == MODE_CLR) begin
        sum   <= '0;
        c_out <= 1'b0;
        ovf   <= 1'b0;
      end else begin
        a_r   <= (mode_e'(mode) == MODE_ACC) ? sum : a;
        b_r   <= (mode_e'(mode) == MODE_SUB) ? ~b : b;
        carry <= (mode_e'(mode) == MODE_SUB) ? 1'b1 : c_in;
      end
    end else if (state == ST_RUN) begin
      sum[{cnt, 2'b00} +: 4] <= sl_s;
      carry                  <= sl_co;
      cnt                    <= cnt + 1'b1;
      if (last) begin
        c_out <= sl_co;
        ovf   <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (sl_s[3] != a_r[WIDTH-1]);
      end
    end
  end

endmodule

// File: tb/tb_ttl_serial_adder.sv
// tb/tb_ttl_serial_adder.sv - self-checking bench for ttl_serial_adder at WIDTH=16
module tb_ttl_serial_adder;
  import ttl_adder_pkg::*;

  localparam int W = 16;
  localparam int N = 4;

  logic         clk;
  logic         reset;
  logic         start;
  logic [1:0]   mode;
  logic [W-1:0] a, b;
  logic         c_in;
  logic         busy, done;
  logic [W-1:0] sum;
  logic         c_out, ovf;

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] acc_m = '0;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } res_t;

  typedef struct {
    logic [1:0]   m;
    logic [W-1:0] av;
    logic [W-1:0] bv;
    logic         cin;
    res_t         exp;
    string        tag;
  } vec_t;

  vec_t vt[9];

  ttl_serial_adder #(.WIDTH(W), .SLICE(4)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .mode  (mode),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .c_out (c_out),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: signed/unsigned integer arithmetic straight from the mode definitions.
  function automatic res_t ref_op(input logic [1:0] m, input logic [W-1:0] av, input logic [W-1:0] bv,
                                  input logic cin, input logic [W-1:0] acc);
    res_t r;
    int u, sg;
    logic [W-1:0] opa;
    r   = '0;
    opa = (m == MODE_ACC) ? acc : av;
    case (m)
      MODE_ADD, MODE_ACC: begin
        u   = int'(opa) + int'(bv) + int'(cin);
        sg  = int'($signed(opa)) + int'($signed(bv)) + int'(cin);
        r.s = u[W-1:0];
        r.c = (u > 65535);
        r.o = (sg > 32767) || (sg < -32768);
      end
      MODE_SUB: begin
        sg  = int'($signed(opa)) - int'($signed(bv));
        r.s = opa - bv;
        r.c = (opa >= bv);
        r.o = (sg > 32767) || (sg < -32768);
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic do_op(input logic [1:0] m, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic cin, input res_t exp, input string tag);
    start = 1'b1;
    mode  = m;
    a     = av;
    b     = bv;
    c_in  = cin;
    step();
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    c_in  = 1'($urandom);
    if (m != MODE_CLR) begin
      for (int k = 0; k < N; k++) begin
        chk($sformatf("%s.busy%0d", tag, k), busy, 1'b1);
        chk($sformatf("%s.nodone%0d", tag, k), done, 1'b0);
        step();
      end
    end
    chk({tag, ".done"}, done, 1'b1);
    chk({tag, ".idlebusy"}, busy, 1'b0);
    chk({tag, ".sum"}, sum, exp.s);
    chk({tag, ".c_out"}, c_out, exp.c);
    chk({tag, ".ovf"}, ovf, exp.o);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b1;
    mode  = MODE_ADD;
    a     = 16'h1111;
    b     = 16'h2222;
    c_in  = 1'b0;
    step();
    step();
    chk("reset.busy", busy, 1'b0);
    chk("reset.done", done, 1'b0);
    chk("reset.sum", sum, 16'h0000);
    chk("reset.c_out", c_out, 1'b0);
    chk("reset.ovf", ovf, 1'b0);
    reset = 1'b0;
    start = 1'b0;
    step();
    chk("post_reset.busy", busy, 1'b0);

    vt[0] = '{MODE_ADD, 16'hFFFF, 16'h0001, 1'b0, '{16'h0000, 1'b1, 1'b0}, "add_wrap"};
    vt[1] = '{MODE_ADD, 16'h7FFF, 16'h0001, 1'b0, '{16'h8000, 1'b0, 1'b1}, "add_ovf"};
    vt[2] = '{MODE_SUB, 16'h8000, 16'h0001, 1'b0, '{16'h7FFF, 1'b1, 1'b1}, "sub_ovf"};
    vt[3] = '{MODE_SUB, 16'h0000, 16'h0001, 1'b1, '{16'hFFFF, 1'b0, 1'b0}, "sub_borrow"};
    vt[4] = '{MODE_CLR, 16'hABCD, 16'h5555, 1'b1, '{16'h0000, 1'b0, 1'b0}, "clr"};
    vt[5] = '{MODE_ACC, 16'hFFFF, 16'h1234, 1'b0, '{16'h1234, 1'b0, 1'b0}, "acc1"};
    vt[6] = '{MODE_ACC, 16'h0F0F, 16'h1234, 1'b0, '{16'h2468, 1'b0, 1'b0}, "acc2"};
    vt[7] = '{MODE_ACC, 16'h0000, 16'h1234, 1'b0, '{16'h369C, 1'b0, 1'b0}, "acc3"};
    vt[8] = '{MODE_ADD, 16'h1234, 16'h4321, 1'b1, '{16'h5556, 1'b0, 1'b0}, "add_cin"};

    for (int i = 0; i < 9; i++) begin
      do_op(vt[i].m, vt[i].av, vt[i].bv, vt[i].cin, vt[i].exp, vt[i].tag);
      acc_m = vt[i].exp.s;
    end
    step();
    chk("table.back_to_idle", done, 1'b0);

    // A start pulsed mid-RUN with other operands must not disturb the result or retrigger.
    start = 1'b1; mode = MODE_ADD; a = 16'h1111; b = 16'h2222; c_in = 1'b0;
    step();
    start = 1'b0;
    step();
    start = 1'b1; mode = MODE_SUB; a = 16'hFFFF; b = 16'h0F0F; c_in = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("ignore.done", done, 1'b1);
    chk("ignore.sum", sum, 16'h3333);
    chk("ignore.c_out", c_out, 1'b0);
    step();
    chk("ignore.no_retrigger_busy", busy, 1'b0);
    chk("ignore.no_retrigger_done", done, 1'b0);
    acc_m = 16'h3333;

    do_op(MODE_ADD, 16'hFFFF, 16'h8000, 1'b0, '{16'h7FFF, 1'b1, 1'b1}, "pre_abort");

    // Reset during the second RUN cycle aborts with no done pulse.
    start = 1'b1; mode = MODE_ADD; a = 16'h1111; b = 16'h2222; c_in = 1'b0;
    step();
    start = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort.busy", busy, 1'b0);
    chk("abort.done", done, 1'b0);
    chk("abort.sum", sum, 16'h0000);
    chk("abort.c_out", c_out, 1'b0);
    chk("abort.ovf", ovf, 1'b0);
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("abort.quiet%0d", k), {busy, done}, 2'b00);
    end
    acc_m = '0;
    do_op(MODE_ACC, 16'h0000, 16'h0001, 1'b1, ref_op(MODE_ACC, 16'h0000, 16'h0001, 1'b1, acc_m), "after_abort");
    acc_m = 16'h0002;

    for (int i = 0; i < 40; i++) begin
      logic [1:0]   m;
      logic [W-1:0] av, bv;
      logic         cin;
      res_t         e;
      m   = 2'($urandom_range(0, 3));
      av  = W'($urandom);
      bv  = W'($urandom);
      cin = 1'($urandom);
      e   = ref_op(m, av, bv, cin, acc_m);
      do_op(m, av, bv, cin, e, $sformatf("rnd%0d", i));
      acc_m = e.s;
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 2)) step();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
